// File: rtl/procyon_mhq_pkg.sv
// Shared types and sizing for the miss handling queue.
// Pulled in by the interface, the entry slice and the top.
package procyon_mhq_pkg;

  localparam int OPTN_ADDR_WIDTH       = 32;
  localparam int OPTN_DC_LINE_SIZE     = 32;
  localparam int OPTN_MHQ_DEPTH        = 4;
  localparam int OPTN_MHQ_IDX_WIDTH    = 2;
  localparam int MHQ_LINE_OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE);
  localparam int DC_LINE_WIDTH         = OPTN_DC_LINE_SIZE * 8;

  typedef logic [OPTN_ADDR_WIDTH-1:0]    addr_t;
  typedef logic [OPTN_MHQ_IDX_WIDTH-1:0] mhq_idx_t;
  typedef logic [DC_LINE_WIDTH-1:0]      line_data_t;

  typedef enum logic [1:0] {
    MHQ_STATE_INVALID = 2'b00,
    MHQ_STATE_PENDING = 2'b01,
    MHQ_STATE_ISSUED  = 2'b10
  } mhq_entry_state_t;

  function automatic addr_t line_align(input addr_t addr);
    return addr & ~addr_t'(OPTN_DC_LINE_SIZE - 1);
  endfunction

endpackage

// File: rtl/procyon_mhq_if.sv
// Lookup, fill-request and fill-broadcast signals of the MHQ.
// The slave modport is the MHQ itself; master is the LQ/memory side.
interface procyon_mhq_if;
  import procyon_mhq_pkg::*;

  logic       i_lookup_en;
  addr_t      i_lookup_addr;
  mhq_idx_t   o_lookup_mhq_tag;
  logic       o_lookup_mhq_retry;
  logic       o_lookup_mhq_replay;
  logic       o_full;
  logic       o_fill_req_valid;
  addr_t      o_fill_req_addr;
  logic       i_fill_req_ready;
  logic       i_fill_resp_valid;
  line_data_t i_fill_resp_data;
  logic       o_fill_en;
  mhq_idx_t   o_fill_tag;
  addr_t      o_fill_addr;
  line_data_t o_fill_data;

  modport slave (
    input  i_lookup_en, i_lookup_addr, i_fill_req_ready, i_fill_resp_valid, i_fill_resp_data,
    output o_lookup_mhq_tag, o_lookup_mhq_retry, o_lookup_mhq_replay, o_full,
           o_fill_req_valid, o_fill_req_addr, o_fill_en, o_fill_tag, o_fill_addr, o_fill_data
  );

  modport master (
    output i_lookup_en, i_lookup_addr, i_fill_req_ready, i_fill_resp_valid, i_fill_resp_data,
    input  o_lookup_mhq_tag, o_lookup_mhq_retry, o_lookup_mhq_replay, o_full,
           o_fill_req_valid, o_fill_req_addr, o_fill_en, o_fill_tag, o_fill_addr, o_fill_data
  );
endinterface

// File: rtl/procyon_mhq_entry.sv
// One MHQ slot: line address plus lifecycle state, with a line-match compare.
// States: INVALID free | PENDING allocated, not requested | ISSUED awaiting line
module procyon_mhq_entry
  import procyon_mhq_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  alloc_en_i,
  input  addr_t alloc_addr_i,
  input  logic  issue_en_i,
  input  logic  fill_en_i,
  input  addr_t lookup_line_i,
  output logic  pending_o,
  output logic  issued_o,
  output logic  match_o,
  output addr_t addr_o
);

  mhq_entry_state_t state_q, state_d;
  addr_t            addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MHQ_STATE_INVALID;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             addr_q <= '0;
    else if (alloc_en_i) addr_q <= alloc_addr_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MHQ_STATE_INVALID: if (alloc_en_i) state_d = MHQ_STATE_PENDING;
      MHQ_STATE_PENDING: if (issue_en_i) state_d = MHQ_STATE_ISSUED;
      MHQ_STATE_ISSUED:  if (fill_en_i)  state_d = MHQ_STATE_INVALID;
      default:                           state_d = MHQ_STATE_INVALID;
    endcase
  end

  always_comb begin
    pending_o = (state_q == MHQ_STATE_PENDING);
    issued_o  = (state_q == MHQ_STATE_ISSUED);
    match_o   = (state_q != MHQ_STATE_INVALID) && (addr_q == lookup_line_i);
    addr_o    = addr_q;
  end

endmodule

// File: rtl/procyon_mhq.sv
// Miss handling queue: merges/allocates misses, issues fills in order, broadcasts returns.
// Build option PCYN_MHQ_MERGE_EN enables merging a lookup onto an in-flight line.
module procyon_mhq
  import procyon_mhq_pkg::*;
(
  input logic          clk,
  input logic          rst,
  procyon_mhq_if.slave mhq
);

  mhq_idx_t   head_q, head_d, tail_q, tail_d, issue_q, issue_d;
  logic       full_q, full_d;
  logic       fill_en_q;
  mhq_idx_t   fill_tag_q;
  addr_t      fill_addr_q;
  line_data_t fill_data_q;

  logic [OPTN_MHQ_DEPTH-1:0] pending_v, issued_v, match_v, alloc_v, issue_v, fill_v;
  addr_t                     entry_addr [OPTN_MHQ_DEPTH];

  addr_t lookup_line;
  logic  replay_hit, any_match, alloc, req_fire;

  assign lookup_line = line_align(mhq.i_lookup_addr);
  assign replay_hit  = fill_en_q && (lookup_line == fill_addr_q);
  assign any_match   = |match_v;
  assign alloc       = mhq.i_lookup_en && !replay_hit && !any_match && !full_q;
  assign req_fire    = pending_v[issue_q] && mhq.i_fill_req_ready;

  for (genvar g = 0; g < OPTN_MHQ_DEPTH; g++) begin : g_entry
    procyon_mhq_entry u_entry (
      .clk           (clk),
      .rst           (rst),
      .alloc_en_i    (alloc_v[g]),
      .alloc_addr_i  (lookup_line),
      .issue_en_i    (issue_v[g]),
      .fill_en_i     (fill_v[g]),
      .lookup_line_i (lookup_line),
      .pending_o     (pending_v[g]),
      .issued_o      (issued_v[g]),
      .match_o       (match_v[g]),
      .addr_o        (entry_addr[g])
    );
  end

  always_comb begin
    alloc_v          = '0;
    issue_v          = '0;
    fill_v           = '0;
    alloc_v[tail_q]  = alloc;
    issue_v[issue_q] = req_fire;
    fill_v[head_q]   = mhq.i_fill_resp_valid;
  end

`ifdef PCYN_MHQ_MERGE_EN
  mhq_idx_t match_idx;
  always_comb begin
    match_idx = '0;
    for (int i = 0; i < OPTN_MHQ_DEPTH; i++) begin
      if (match_v[i]) match_idx = mhq_idx_t'(i);
    end
  end
`endif

  // Replay beats merge beats allocate; a slot freed this cycle is not yet visible.
  always_comb begin
    mhq.o_lookup_mhq_tag    = head_q;
    mhq.o_lookup_mhq_retry  = 1'b0;
    mhq.o_lookup_mhq_replay = 1'b0;
    if (replay_hit) begin
      mhq.o_lookup_mhq_replay = 1'b1;
      mhq.o_lookup_mhq_tag    = fill_tag_q;
    end else if (any_match) begin
`ifdef PCYN_MHQ_MERGE_EN
      mhq.o_lookup_mhq_tag    = match_idx;
`else
      mhq.o_lookup_mhq_retry  = 1'b1;
`endif
    end else if (!full_q) begin
      mhq.o_lookup_mhq_tag    = tail_q;
    end else begin
      mhq.o_lookup_mhq_retry  = 1'b1;
    end
  end

  always_comb begin
    head_d  = head_q + mhq_idx_t'(mhq.i_fill_resp_valid);
    tail_d  = tail_q + mhq_idx_t'(alloc);
    issue_d = issue_q + mhq_idx_t'(req_fire);
    full_d  = full_q;
    if (mhq.i_fill_resp_valid)                                   full_d = 1'b0;
    else if (alloc && (mhq_idx_t'(tail_q + 1'b1) == head_q))     full_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      issue_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      issue_q <= issue_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_en_q   <= 1'b0;
      fill_tag_q  <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      fill_en_q <= mhq.i_fill_resp_valid;
      if (mhq.i_fill_resp_valid) begin
        fill_tag_q  <= head_q;
        fill_addr_q <= entry_addr[head_q];
        fill_data_q <= mhq.i_fill_resp_data;
      end
    end
  end

  assign mhq.o_full           = full_q;
  assign mhq.o_fill_req_valid = pending_v[issue_q];
  assign mhq.o_fill_req_addr  = entry_addr[issue_q];
  assign mhq.o_fill_en        = fill_en_q;
  assign mhq.o_fill_tag       = fill_tag_q;
  assign mhq.o_fill_addr      = fill_addr_q;
  assign mhq.o_fill_data      = fill_data_q;

  a_resp_needs_issued_head: assert property (
    @(posedge clk) disable iff (rst) mhq.i_fill_resp_valid |-> issued_v[head_q]
  ) else $error("fill response arrived while head entry is not issued");

endmodule

// File: tb/tb_procyon_mhq.sv
// Directed plus random bench for procyon_mhq against an in-order queue model.
module tb_procyon_mhq;
  import procyon_mhq_pkg::*;

`ifdef PCYN_MHQ_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  procyon_mhq_if mhq ();
  procyon_mhq dut (.clk(clk), .rst(rst), .mhq(mhq));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: outstanding lines in allocation order; the first n_issued have been requested.
  addr_t      q_line [$];
  logic [1:0] q_tag  [$];
  int         n_issued;
  logic [1:0] head_ctr, tail_ctr;
  bit         fb_en;
  logic [1:0] fb_tag;
  addr_t      fb_line;
  line_data_t fb_data;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic line_data_t rand_line();
    line_data_t r;
    for (int k = 0; k < DC_LINE_WIDTH / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    q_line.delete();
    q_tag.delete();
    n_issued = 0;
    head_ctr = '0;
    tail_ctr = '0;
    fb_en    = 1'b0;
    fb_tag   = '0;
    fb_line  = '0;
    fb_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mhq.i_lookup_en       = 1'b0;
    mhq.i_lookup_addr     = '0;
    mhq.i_fill_req_ready  = 1'b0;
    mhq.i_fill_resp_valid = 1'b0;
    mhq.i_fill_resp_data  = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_fill_en",   256'(mhq.o_fill_en),        256'(0));
    chk("rst_req_valid", 256'(mhq.o_fill_req_valid), 256'(0));
    chk("rst_full",      256'(mhq.o_full),           256'(0));
    chk("rst_fill_tag",  256'(mhq.o_fill_tag),       256'(0));
    chk("rst_fill_addr", 256'(mhq.o_fill_addr),      256'(0));
    chk("rst_fill_data", 256'(mhq.o_fill_data),      256'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit en, input addr_t a, input bit rdy, input bit rv);
    line_data_t d;
    addr_t      line;
    logic [1:0] tag_e;
    bit         retry_e, replay_e, alloc;
    int         mi;
    @(negedge clk);
    if (n_issued == 0) rv = 1'b0;
    d = rand_line();
    mhq.i_lookup_en       = en;
    mhq.i_lookup_addr     = a;
    mhq.i_fill_req_ready  = rdy;
    mhq.i_fill_resp_valid = rv;
    mhq.i_fill_resp_data  = d;
    #1;
    line = a & ~addr_t'(OPTN_DC_LINE_SIZE - 1);
    mi = -1;
    foreach (q_line[k]) if (q_line[k] == line) mi = k;
    tag_e = head_ctr; retry_e = 1'b0; replay_e = 1'b0; alloc = 1'b0;
    if (fb_en && line == fb_line) begin
      replay_e = 1'b1; tag_e = fb_tag;
    end else if (mi >= 0) begin
      if (MERGE_EN) tag_e = q_tag[mi];
      else          retry_e = 1'b1;
    end else if (q_line.size() < OPTN_MHQ_DEPTH) begin
      tag_e = tail_ctr; alloc = en;
    end else begin
      retry_e = 1'b1;
    end
    if (en) begin
      chk("lookup_tag",    256'(mhq.o_lookup_mhq_tag),    256'(tag_e));
      chk("lookup_retry",  256'(mhq.o_lookup_mhq_retry),  256'(retry_e));
      chk("lookup_replay", 256'(mhq.o_lookup_mhq_replay), 256'(replay_e));
    end
    chk("full", 256'(mhq.o_full), 256'(q_line.size() == OPTN_MHQ_DEPTH));
    chk("req_valid", 256'(mhq.o_fill_req_valid), 256'(n_issued < q_line.size()));
    if (n_issued < q_line.size())
      chk("req_addr", 256'(mhq.o_fill_req_addr), 256'(q_line[n_issued]));
    chk("fill_en", 256'(mhq.o_fill_en), 256'(fb_en));
    if (fb_en) begin
      chk("fill_tag",  256'(mhq.o_fill_tag),  256'(fb_tag));
      chk("fill_addr", 256'(mhq.o_fill_addr), 256'(fb_line));
      chk("fill_data", 256'(mhq.o_fill_data), fb_data);
    end
    if (rdy && n_issued < q_line.size()) n_issued++;
    fb_en = rv;
    if (rv) begin
      fb_tag  = head_ctr;
      fb_line = q_line.pop_front();
      void'(q_tag.pop_front());
      fb_data = d;
      head_ctr++;
      n_issued--;
    end
    if (alloc) begin
      q_line.push_back(line);
      q_tag.push_back(tail_ctr);
      tail_ctr++;
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // single miss: allocate, request, fill, broadcast
    step(1, 32'h1004, 0, 0);
    step(0, 32'h0,    1, 0);
    step(0, 32'h0,    0, 1);
    step(0, 32'h0,    0, 0);
    step(0, 32'h0,    0, 0);

    // second lookup to an issued line: merge or retry
    do_reset();
    step(1, 32'h1004, 0, 0);
    step(0, 32'h0,    1, 0);
    step(1, 32'h101C, 0, 0);
    step(0, 32'h0,    0, 1);
    step(0, 32'h0,    0, 0);

    // fill the queue, retry when full and when freeing in the same cycle
    do_reset();
    step(1, 32'h00, 0, 0);
    step(1, 32'h20, 0, 0);
    step(1, 32'h40, 0, 0);
    step(1, 32'h60, 0, 0);
    step(1, 32'h80, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0);
    step(1, 32'h80, 0, 1);
    step(1, 32'h80, 0, 0);
    // request held while ready is low
    for (int i = 0; i < 5; i++) step(0, 32'h0, 0, 0);
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 1);
    // lookup of the line being broadcast replays
    step(1, 32'h40, 0, 0);
    step(0, 32'h0,  0, 1);
    step(0, 32'h0,  0, 1);
    step(0, 32'h0,  0, 0);

    // reset while a request is outstanding
    do_reset();
    step(1, 32'h2000, 0, 0);
    step(0, 32'h0,    1, 0);
    do_reset();
    step(1, 32'h3000, 0, 0);
    step(0, 32'h0,    0, 0);

    // random traffic over a small set of lines
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)),
           32'h4000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31)),
           bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
